pipo_load_arbiter: RTL and testbench

PIPO_LOAD_ARBITER -- requirements
Module: pipo_load_arbiter

---
 rtl/pipo_load_arbiter_if.sv | 25 ++
 rtl/pipo_load_arbiter.sv | 118 +++++++++++
 tb/tb_pipo_load_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pipo_load_arbiter_if.sv
// Bus bundle for the two-requester PIPO load arbiter.
// The arbiter takes the slave side; requesters (or a testbench) drive the master side.
interface pipo_load_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             gnt0;
  logic             gnt1;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             busy;

  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1, data_out, valid_out, busy
  );

  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1, data_out, valid_out, busy
  );
endinterface

// File: rtl/pipo_load_arbiter.sv
// Two-requester arbiter in front of a shared parallel-in parallel-out register.
// A load grants one requester, captures its data and then locks the register
// for HOLD cycles. Simultaneous requests are resolved round-robin via a 1-bit
// last-grant pointer, or with fixed req0 priority when the macro
// PIPO_LOAD_ARB_FIXED_PRIO_EN is defined (the pointer then does not exist).
module pipo_load_arbiter #(
  parameter int WIDTH = 4,
  parameter int HOLD  = 2
) (
  input  logic               clk,
  input  logic               rst,
  pipo_load_arbiter_if.slave bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  // Counter reload value: HOLD-1 more edges in the hold state after the load edge.
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD - 1);

  state_t           state_r;
  logic [3:0]       cnt_r;
  logic             gnt0_r;
  logic             gnt1_r;
  logic [WIDTH-1:0] data_out_r;
  logic             valid_r;
  logic             busy_r;

  logic             pick0_s;
  logic             pick1_s;
  logic [WIDTH-1:0] win_data_s;

`ifndef PIPO_LOAD_ARB_FIXED_PRIO_EN
  // Last winner: 1 means requester 1 won last, so requester 0 is preferred next.
  logic             ptr_r;
`endif

  // Choose the winner among the current requests; only used while idle.
  always_comb begin
    pick0_s    = 1'b0;
    pick1_s    = 1'b0;
    win_data_s = {WIDTH{1'b0}};
`ifdef PIPO_LOAD_ARB_FIXED_PRIO_EN
    pick0_s = bus.req0;
`else
    pick0_s = bus.req0 & (~bus.req1 | ptr_r);
`endif
    pick1_s = bus.req1 & ~pick0_s;
    if (pick0_s) begin
      win_data_s = bus.data0;
    end else begin
      win_data_s = bus.data1;
    end
  end

  // Arbitration FSM: grant and load in idle, count down the lock in hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      cnt_r      <= 4'd0;
      gnt0_r     <= 1'b0;
      gnt1_r     <= 1'b0;
      data_out_r <= {WIDTH{1'b0}};
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
`ifndef PIPO_LOAD_ARB_FIXED_PRIO_EN
      ptr_r      <= 1'b1;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (pick0_s || pick1_s) begin
            data_out_r <= win_data_s;
            gnt0_r     <= pick0_s;
            gnt1_r     <= pick1_s;
            valid_r    <= 1'b1;
            busy_r     <= 1'b1;
            cnt_r      <= HOLD_LOAD;
            state_r    <= S_HOLD;
`ifndef PIPO_LOAD_ARB_FIXED_PRIO_EN
            ptr_r      <= pick1_s;
`endif
          end else begin
            gnt0_r <= 1'b0;
            gnt1_r <= 1'b0;
            busy_r <= 1'b0;
          end
        end
        S_HOLD: begin
          gnt0_r <= 1'b0;
          gnt1_r <= 1'b0;
          if (cnt_r == 4'd0) begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          gnt0_r  <= 1'b0;
          gnt1_r  <= 1'b0;
          busy_r  <= 1'b0;
          cnt_r   <= 4'd0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0      = gnt0_r;
  assign bus.gnt1      = gnt1_r;
  assign bus.data_out  = data_out_r;
  assign bus.valid_out = valid_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Directed bench for pipo_load_arbiter (WIDTH=4, HOLD=2).
// Honours PIPO_LOAD_ARB_FIXED_PRIO_EN for the simultaneous-request expectations.
module tb_pipo_load_arbiter;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  pipo_load_arbiter_if #(.WIDTH(4)) bus ();

  pipo_load_arbiter #(.WIDTH(4), .HOLD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic g0, input logic g1,
                         input logic [3:0] d, input logic v, input logic b);
    chk({tag, ".gnt0"}, {7'd0, bus.gnt0}, {7'd0, g0});
    chk({tag, ".gnt1"}, {7'd0, bus.gnt1}, {7'd0, g1});
    chk({tag, ".data_out"}, {4'd0, bus.data_out}, {4'd0, d});
    chk({tag, ".valid_out"}, {7'd0, bus.valid_out}, {7'd0, v});
    chk({tag, ".busy"}, {7'd0, bus.busy}, {7'd0, b});
  endtask

  initial begin
    logic       eg0;
    logic       eg1;
    logic [3:0] ed;
    nvec = 0;
    nerr = 0;
    rst       = 1'b0;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.data0 = 4'h0;
    bus.data1 = 4'h0;

    // Reset state, before any clock edge.
    #2;
    chk_out("reset", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;

    // Single load from requester 0.
    bus.req0  = 1'b1;
    bus.data0 = 4'b1010;
    tick();
    chk_out("load0.e1", 1'b1, 1'b0, 4'b1010, 1'b1, 1'b1);
    bus.req0 = 1'b0;
    tick();
    chk_out("load0.e2", 1'b0, 1'b0, 4'b1010, 1'b1, 1'b1);
    tick();
    chk_out("load0.e3", 1'b0, 1'b0, 4'b1010, 1'b1, 1'b0);
    tick();
    chk_out("idle.hold", 1'b0, 1'b0, 4'b1010, 1'b1, 1'b0);

    // Fresh reset so the pointer prefers requester 0 again.
    rst = 1'b0;
    #2;
    rst = 1'b1;

    // Both requesters held high.
    bus.req0  = 1'b1;
    bus.data0 = 4'b1011;
    bus.req1  = 1'b1;
    bus.data1 = 4'b1001;
    for (int k = 0; k < 9; k++) begin
      tick();
      eg0 = 1'b0;
      eg1 = 1'b0;
`ifdef PIPO_LOAD_ARB_FIXED_PRIO_EN
      if (k % 3 == 0) eg0 = 1'b1;
      ed = 4'b1011;
`else
      if (k == 0 || k == 6) eg0 = 1'b1;
      if (k == 3) eg1 = 1'b1;
      ed = (k >= 3 && k < 6) ? 4'b1001 : 4'b1011;
`endif
      chk_out($sformatf("both.k%0d", k), eg0, eg1, ed, 1'b1, (k % 3 != 2));
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();
    chk_out("both.idle", 1'b0, 1'b0, ed, 1'b1, 1'b0);

    // Request from requester 1 arriving during a hold.
    bus.req0  = 1'b1;
    bus.data0 = 4'b0011;
    tick();
    chk_out("hold.g0", 1'b1, 1'b0, 4'b0011, 1'b1, 1'b1);
    bus.req0  = 1'b0;
    bus.req1  = 1'b1;
    bus.data1 = 4'b1100;
    tick();
    chk_out("hold.e2", 1'b0, 1'b0, 4'b0011, 1'b1, 1'b1);
    tick();
    chk_out("hold.e3", 1'b0, 1'b0, 4'b0011, 1'b1, 1'b0);
    tick();
    chk_out("hold.g1", 1'b0, 1'b1, 4'b1100, 1'b1, 1'b1);
    bus.req1 = 1'b0;
    tick();
    chk_out("hold.mid", 1'b0, 1'b0, 4'b1100, 1'b1, 1'b1);

    // Reset pulsed mid-hold acts immediately.
    #2;
    rst = 1'b0;
    #1;
    chk_out("midrst", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    bus.req1  = 1'b1;
    bus.data1 = 4'b0110;
    tick();
    chk_out("postrst.g1", 1'b0, 1'b1, 4'b0110, 1'b1, 1'b1);
    bus.req1 = 1'b0;
    tick();
    tick();
    tick();
    chk_out("postrst.idle", 1'b0, 1'b0, 4'b0110, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
